// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared defaults, entry layout and read FSM states for the UART RX FIFO
package uart_rx_fifo_pkg;
  localparam int RX_FIFO_DEPTH_LOG2 = 4;
  localparam int RX_DATA_W = 8;
  localparam int RX_EOP_BIT = RX_DATA_W;
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DONE = 1'b1
  } rd_state_e;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and bus-side signals of the UART RX FIFO
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
  parameter int DATA_W = RX_DATA_W
);
  logic rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic rx_eop;
  logic rd_q;
  logic rd_dn;
  logic [DATA_W:0] rd_data;
  logic empty;
  logic full;
  logic [DEPTH_LOG2:0] count;
  logic overrun;
  logic ovr_clr;
  modport master (
    output rx_valid, rx_data, rx_eop, rd_q, ovr_clr,
    input rd_dn, rd_data, empty, full, count, overrun
  );
  modport slave (
    input rx_valid, rx_data, rx_eop, rd_q, ovr_clr,
    output rd_dn, rd_data, empty, full, count, overrun
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: register array with a write port, an MSB-set port and a registered read port
module sync_fifo_mem #(
  parameter int W = 9,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);
  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rd_data_q;
  // set port only ever targets an entry other than the one being written
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (set_en_i) mem_q[set_addr_i][W-1] <= 1'b1;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end
  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO with EOP tagging, sticky overrun and one-byte-per-read bus port
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
  parameter int DATA_W = RX_DATA_W
) (
  input logic clk,
  input logic rst,
  uart_rx_fifo_if.slave bus_if
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic rx_valid_q;
  logic eop_pend_q, eop_pend_d;
  logic ovr_q, ovr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_ptr;
  logic [DEPTH_LOG2:0] count_q, count_d;
  rd_state_e state_q, state_d;
  logic push_req, push, pop, empty, full, tag;
  logic [DATA_W:0] mem_rd;
  always_comb begin
    empty = count_q == '0;
    full = count_q == FULL_CNT;
    push_req = bus_if.rx_valid && !rx_valid_q;
    pop = bus_if.rd_q && !empty && state_q == RD_IDLE;
    push = push_req && (!full || pop);
    // tag only an entry that survives this cycle's pop
    tag = bus_if.rx_eop && !push && !empty && !(pop && count_q == {{DEPTH_LOG2{1'b0}}, 1'b1});
    last_ptr = wr_ptr_q - DEPTH_LOG2'(1);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d = count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    eop_pend_d = push ? 1'b0 : (bus_if.rx_eop && empty) ? 1'b1 : eop_pend_q;
    ovr_d = (push_req && !push) ? 1'b1 : bus_if.ovr_clr ? 1'b0 : ovr_q;
    state_d = (state_q == RD_IDLE && pop) ? RD_DONE : RD_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      eop_pend_q <= 1'b0;
      ovr_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      state_q <= RD_IDLE;
    end else begin
      rx_valid_q <= bus_if.rx_valid;
      eop_pend_q <= eop_pend_d;
      ovr_q <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end
  sync_fifo_mem #(.W(DATA_W + 1), .AW(DEPTH_LOG2)) u_mem (
    .clk(clk),
    .wr_en_i(push),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i({bus_if.rx_eop | eop_pend_q, bus_if.rx_data}),
    .set_en_i(tag),
    .set_addr_i(last_ptr),
    .rd_en_i(pop),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(mem_rd)
  );
  assign bus_if.rd_dn = state_q == RD_DONE;
  assign bus_if.rd_data = (state_q == RD_DONE) ? mem_rd : '0;
  assign bus_if.empty = empty;
  assign bus_if.full = full;
  assign bus_if.count = count_q;
  assign bus_if.overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vectors, corner sequences and randomized run against a queue model
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_rx_fifo_if bus ();
  uart_rx_fifo dut (.clk(clk), .rst(rst), .bus_if(bus));
  int tests = 0;
  int fails = 0;
  logic [8:0] mq[$];
  logic m_pend, m_ovr, m_prev, m_dn;
  logic [8:0] m_data;
  typedef struct {
    logic rv;
    logic [7:0] d;
    logic eop;
    logic rq;
    logic dn;
    logic [8:0] data;
    logic [4:0] cnt;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model();
    logic edge_v, acc;
    logic [8:0] t;
    int sz0;
    if (rst) begin
      mq.delete();
      m_pend = 0; m_ovr = 0; m_prev = 0; m_dn = 0; m_data = 0;
      return;
    end
    edge_v = bus.rx_valid && !m_prev;
    m_prev = bus.rx_valid;
    sz0 = mq.size();
    if (bus.rd_q && sz0 > 0 && !m_dn) begin
      m_data = mq.pop_front();
      m_dn = 1;
    end else begin
      m_data = 0;
      m_dn = 0;
    end
    acc = 0;
    if (edge_v && mq.size() < 16) begin
      mq.push_back({bus.rx_eop | m_pend, bus.rx_data});
      acc = 1;
      m_pend = 0;
    end
    if (edge_v && !acc) m_ovr = 1;
    else if (bus.ovr_clr) m_ovr = 0;
    if (bus.rx_eop && !acc) begin
      if (mq.size() > 0) begin
        t = mq[mq.size()-1];
        t[8] = 1'b1;
        mq[mq.size()-1] = t;
      end else if (sz0 == 0) m_pend = 1;
    end
  endtask
  task automatic cyc();
    model();
    @(posedge clk);
    #1;
    chk("model", {bus.rd_dn, bus.rd_data, bus.count, bus.empty, bus.full, bus.overrun},
        {m_dn, m_data, 5'(mq.size()), mq.size() == 0, mq.size() == 16, m_ovr});
  endtask
  task automatic push(logic [7:0] b);
    bus.rx_valid = 1; bus.rx_data = b;
    cyc();
    bus.rx_valid = 0;
    cyc();
  endtask
  initial begin
    bus.rx_valid = 0; bus.rx_data = 0; bus.rx_eop = 0; bus.rd_q = 0; bus.ovr_clr = 0;
    tbl[0]  = '{1, 8'h41, 0, 0, 0, 9'h000, 5'd1};
    tbl[1]  = '{1, 8'h41, 0, 0, 0, 9'h000, 5'd1};
    tbl[2]  = '{0, 8'h00, 0, 0, 0, 9'h000, 5'd1};
    tbl[3]  = '{1, 8'h42, 0, 0, 0, 9'h000, 5'd2};
    tbl[4]  = '{0, 8'h00, 0, 0, 0, 9'h000, 5'd2};
    tbl[5]  = '{1, 8'h43, 1, 0, 0, 9'h000, 5'd3};
    tbl[6]  = '{0, 8'h00, 0, 1, 1, 9'h041, 5'd2};
    tbl[7]  = '{0, 8'h00, 0, 0, 0, 9'h000, 5'd2};
    tbl[8]  = '{0, 8'h00, 0, 1, 1, 9'h042, 5'd1};
    tbl[9]  = '{0, 8'h00, 0, 1, 0, 9'h000, 5'd1};
    tbl[10] = '{0, 8'h00, 0, 1, 1, 9'h143, 5'd0};
    tbl[11] = '{0, 8'h00, 1, 0, 0, 9'h000, 5'd0};
    tbl[12] = '{1, 8'h20, 0, 0, 0, 9'h000, 5'd1};
    tbl[13] = '{0, 8'h00, 0, 1, 1, 9'h120, 5'd0};
    tbl[14] = '{0, 8'h00, 0, 0, 0, 9'h000, 5'd0};
    repeat (2) cyc();
    chk("reset", {bus.rd_dn, bus.rd_data, bus.count, bus.empty, bus.full, bus.overrun}, 18'h4);
    rst = 0;
    for (int i = 0; i < 15; i++) begin
      bus.rx_valid = tbl[i].rv; bus.rx_data = tbl[i].d; bus.rx_eop = tbl[i].eop; bus.rd_q = tbl[i].rq;
      cyc();
      chk($sformatf("vec%0d", i), {bus.rd_dn, bus.rd_data, bus.count}, {tbl[i].dn, tbl[i].data, tbl[i].cnt});
    end
    bus.rx_eop = 0;
    chk("vec_empty", bus.empty, 1);
    bus.rx_valid = 1; bus.rx_data = 8'h55;
    repeat (10) cyc();
    bus.rx_valid = 0;
    cyc();
    chk("hold_count", bus.count, 1);
    bus.rd_q = 1;
    cyc();
    chk("hold_read", {bus.rd_dn, bus.rd_data}, {1'b1, 9'h055});
    bus.rd_q = 0;
    cyc();
    for (int i = 1; i <= 17; i++) begin
      push(8'(i));
      if (i == 15) chk("not_full15", bus.full, 0);
      if (i == 16) chk("full16", {bus.full, bus.overrun}, 2'b10);
    end
    chk("ovr17", {bus.count, bus.overrun}, {5'd16, 1'b1});
    for (int i = 1; i <= 16; i++) begin
      bus.rd_q = 1;
      cyc();
      chk($sformatf("drain%0d", i), {bus.rd_dn, bus.rd_data}, {1'b1, 9'(i)});
      bus.rd_q = 0;
      cyc();
    end
    chk("ovr_sticky", {bus.empty, bus.overrun}, 2'b11);
    bus.ovr_clr = 1;
    cyc();
    bus.ovr_clr = 0;
    chk("ovr_clr", bus.overrun, 0);
    bus.rd_q = 1;
    repeat (3) cyc();
    chk("rdq_empty", bus.rd_dn, 0);
    bus.rx_valid = 1; bus.rx_data = 8'h7E;
    cyc();
    chk("late_n", {bus.rd_dn, bus.count}, {1'b0, 5'd1});
    bus.rx_valid = 0;
    cyc();
    chk("late_n2", {bus.rd_dn, bus.rd_data}, {1'b1, 9'h07E});
    bus.rd_q = 0;
    cyc();
    for (int i = 0; i < 16; i++) push(8'hB0 + 8'(i));
    bus.rx_valid = 1; bus.rx_data = 8'hAA; bus.rd_q = 1;
    cyc();
    chk("full_pushpop", {bus.count, bus.overrun, bus.rd_dn, bus.rd_data}, {5'd16, 1'b0, 1'b1, 9'h0B0});
    bus.rx_valid = 0; bus.rd_q = 0;
    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    chk("five", bus.count, 5);
    rst = 1; bus.rd_q = 1;
    cyc();
    chk("mid_rst", {bus.count, bus.empty, bus.rd_dn}, {5'd0, 1'b1, 1'b0});
    rst = 0; bus.rd_q = 0;
    cyc();
    for (int blk = 0; blk < 6; blk++) begin
      for (int n = 0; n < 500; n++) begin
        bus.rx_valid = $urandom_range(0, 2) != 0;
        bus.rx_data = 8'($urandom);
        bus.rx_eop = $urandom_range(0, 7) == 0;
        bus.rd_q = $urandom_range(0, 9) < (blk % 3) * 4;
        bus.ovr_clr = $urandom_range(0, 15) == 0;
        rst = $urandom_range(0, 399) == 0;
        cyc();
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
